// File: rtl/instruction_fetch_unit.sv
// Fetch stage and IF/ID pipeline register: owns the PC, runs the req/ready instruction port,
// and absorbs decode stalls (one-entry hold buffer) and branch flushes (drain of in-flight fetch).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IFID_Valid,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct
);

  typedef enum logic [1:0] {StStart, StFetch, StHold, StDrain} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] redirPc;
  logic [31:0] holdBuf;
  logic [31:0] pcPlus4;
  logic [31:0] target;
  logic        unusedTgtBits;

  assign pcPlus4       = pc + 32'd4;
  assign target        = {BranchTarget[31:2], 2'b00};
  assign unusedTgtBits = ^BranchTarget[1:0];

  assign IMemAddr = pc;
  // Empty IF/ID presents an unused opcode so ControlUnit falls to its no-write default.
  assign OpCode   = IFID_Valid ? IFID_Instr[31:26] : 6'b111111;
  assign Funct    = IFID_Instr[5:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StStart;
      pc           <= RESET_PC;
      redirPc      <= RESET_PC;
      holdBuf      <= 32'h0;
      IMemReq      <= 1'b0;
      IFID_Valid   <= 1'b0;
      IFID_Instr   <= 32'h0;
      IFID_PCPlus4 <= 32'h0;
    end else begin
      case (state)
        StStart: begin
          if (BranchTaken) pc <= target;
          IMemReq <= 1'b1;
          state   <= StFetch;
        end
        StFetch: begin
          if (BranchTaken) begin
            IFID_Valid <= 1'b0;
            if (IMemReady) begin
              pc <= target;
            end else begin
              // Request must stay stable, so the redirect waits for the reply to drain.
              redirPc <= target;
              state   <= StDrain;
            end
          end else if (IMemReady) begin
            pc <= pcPlus4;
            if (Stall && IFID_Valid) begin
              holdBuf <= IMemData;
              IMemReq <= 1'b0;
              state   <= StHold;
            end else begin
              IFID_Instr   <= IMemData;
              IFID_PCPlus4 <= pcPlus4;
              IFID_Valid   <= 1'b1;
            end
          end else if (!Stall) begin
            IFID_Valid <= 1'b0;
          end
        end
        StHold: begin
          if (BranchTaken) begin
            pc         <= target;
            IFID_Valid <= 1'b0;
            IMemReq    <= 1'b1;
            state      <= StFetch;
          end else if (!Stall) begin
            // pc already advanced past the held word, so it is the held word's PC+4.
            IFID_Instr   <= holdBuf;
            IFID_PCPlus4 <= pc;
            IFID_Valid   <= 1'b1;
            IMemReq      <= 1'b1;
            state        <= StFetch;
          end
        end
        StDrain: begin
          if (BranchTaken) redirPc <= target;
          if (IMemReady) begin
            pc    <= BranchTaken ? target : redirPc;
            state <= StFetch;
          end
        end
        default: state <= StStart;
      endcase
    end
  end

endmodule
